// File: rtl/matrix_mac_ctrl_pkg.sv
// Shared definitions for the matrix MAC controller and its byte-lane datapath.
// Holds the mul_ctrl command encodings and the per-lane multiply-accumulate helper.
package matrix_mac_ctrl_pkg;

    localparam logic [3:0] MulCtrlNop = 4'b0000;
    localparam logic [3:0] MulCtrlMac = 4'b0001;

    // 8-bit result keeps only the low product byte; lanes wrap mod 256 with no carry-out
    function automatic logic [7:0] lane_mac(input logic [7:0] acc,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        return acc + a * b;
    endfunction

endpackage

// File: rtl/matrix_mac_ctrl_mul.sv
// Combinational 4x4 byte-lane rank-1 update: row j, lane i gets acc + a[i]*b[j].
// Any command other than MulCtrlMac passes the accumulator rows through unchanged.
module matrix_mul
    import matrix_mac_ctrl_pkg::*;
(
    input  logic [3:0]   mul_ctrl,
    input  logic [127:0] acc_in,
    input  logic [31:0]  op_a,
    input  logic [31:0]  op_b,
    output logic [127:0] acc_out
);

    for (genvar j = 0; j < 4; j++) begin : g_row
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign acc_out[32*j+8*i +: 8] = (mul_ctrl == MulCtrlMac) ?
                lane_mac(acc_in[32*j+8*i +: 8], op_a[8*i +: 8], op_b[8*j +: 8]) :
                acc_in[32*j+8*i +: 8];
        end
    end

endmodule

// File: rtl/matrix_mac_ctrl.sv
// Sequencer for the 4x4 byte-lane MAC: clears the accumulator rows, applies K rank-1
// updates over the operand handshake, then streams the four rows out over the result handshake.
module matrix_mac_ctrl
    import matrix_mac_ctrl_pkg::*;
#(
    parameter int unsigned K_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    output logic           busy,
    output logic           done,
    input  logic           opnd_valid,
    output logic           opnd_ready,
    input  logic [31:0]    opnd_a,
    input  logic [31:0]    opnd_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [31:0]    res_data,
    output logic [1:0]     res_row
);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

    localparam logic [K_W-1:0] KOne = {{(K_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [3:0][31:0]  m_q, m_d;
    logic [K_W-1:0]    count_q, count_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [1:0]        row_q, row_d;
    logic              done_q, done_d;

    logic [3:0]        mul_ctrl;
    logic [127:0]      mul_rows;

    matrix_mul u_matrix_mul (
        .mul_ctrl (mul_ctrl),
        .acc_in   (m_q),
        .op_a     (opnd_a),
        .op_b     (opnd_b),
        .acc_out  (mul_rows)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        count_d  = count_q;
        k_d      = k_q;
        row_d    = row_q;
        done_d   = 1'b0;
        mul_ctrl = MulCtrlNop;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = k_len;
                    m_d     = '0;
                    count_d = '0;
                    row_d   = '0;
                    state_d = (k_len != '0) ? StAccum : StDrain;
                end
            end
            StAccum: begin
                if (opnd_valid) begin
                    mul_ctrl = MulCtrlMac;
                    m_d      = mul_rows;
                    count_d  = count_q + KOne;
                    if (count_q == k_q - KOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (res_ready) begin
                    if (row_q == 2'd3) begin
                        state_d = StIdle;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            count_q <= '0;
            k_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            count_q <= count_d;
            k_q     <= k_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign opnd_ready = (state_q == StAccum);
    assign res_valid  = (state_q == StDrain);
    assign res_data   = m_q[row_q];
    assign res_row    = row_q;
    assign done       = done_q;

endmodule

// File: tb/tb_matrix_mac_ctrl.sv
// Bench for matrix_mac_ctrl: directed and randomized runs checked against a per-lane
// byte model with random operand gaps, result backpressure and ignored start pulses.
module tb_matrix_mac_ctrl;

    localparam int K_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy;
    logic           done;
    logic           opnd_valid;
    logic           opnd_ready;
    logic [31:0]    opnd_a;
    logic [31:0]    opnd_b;
    logic           res_valid;
    logic           res_ready;
    logic [31:0]    res_data;
    logic [1:0]     res_row;

    matrix_mac_ctrl #(.K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_row    (res_row)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          model [4][4];
    logic [31:0] a_q [$];
    logic [31:0] b_q [$];
    int          gap_q [$];
    int          stall [4];
    bit          poke_start;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_row(input int j);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = model[j][i][7:0];
        return r;
    endfunction

    task automatic add_op(input logic [31:0] a, input logic [31:0] b, input int gap);
        a_q.push_back(a);
        b_q.push_back(b);
        gap_q.push_back(gap);
    endtask

    task automatic set_stall(input int s0, input int s1, input int s2, input int s3);
        stall[0] = s0;
        stall[1] = s1;
        stall[2] = s2;
        stall[3] = s3;
    endtask

    // One complete start/accumulate/drain transaction using the queued operands
    task automatic run(input int k);
        logic [31:0] a, b;
        int          g;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) model[j][i] = 0;
        start = 1'b1;
        k_len = K_W'(k);
        step();
        start = 1'b0;
        chkb("busy_after_start", busy, 1'b1);
        chkb("done_after_start", done, 1'b0);
        if (k > 0) chkb("opnd_ready_accum", opnd_ready, 1'b1);
        for (int p = 0; p < k; p++) begin
            a = a_q.pop_front();
            b = b_q.pop_front();
            g = gap_q.pop_front();
            opnd_valid = 1'b0;
            for (int c = 0; c < g; c++) begin
                if (poke_start) begin
                    start = 1'b1;
                    k_len = K_W'($urandom_range(0, 255));
                end
                step();
                start = 1'b0;
                chkb("opnd_ready_gap", opnd_ready, 1'b1);
                chkb("res_valid_gap", res_valid, 1'b0);
            end
            opnd_valid = 1'b1;
            opnd_a     = a;
            opnd_b     = b;
            step();
            opnd_valid = 1'b0;
            opnd_a     = $urandom;
            opnd_b     = $urandom;
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++)
                    model[j][i] = (model[j][i] + int'(a[8*i +: 8]) * int'(b[8*j +: 8])) % 256;
        end
        chkb("opnd_ready_drain", opnd_ready, 1'b0);
        chkb("res_valid_drain", res_valid, 1'b1);
        for (int r = 0; r < 4; r++) begin
            res_ready = 1'b0;
            for (int c = 0; c < stall[r]; c++) begin
                step();
                chk("res_row_stall", {30'b0, res_row}, 32'(r));
                chk("res_data_stall", res_data, model_row(r));
                chkb("done_stall", done, 1'b0);
            end
            chk("res_row", {30'b0, res_row}, 32'(r));
            chk("res_data", res_data, model_row(r));
            chkb("res_valid", res_valid, 1'b1);
            chkb("done_early", done, 1'b0);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
        end
        chkb("done_pulse", done, 1'b1);
        chkb("busy_end", busy, 1'b0);
        chkb("res_valid_end", res_valid, 1'b0);
        step();
        chkb("done_drop", done, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        k_len      = '0;
        opnd_valid = 1'b0;
        opnd_a     = '0;
        opnd_b     = '0;
        res_ready  = 1'b0;
        poke_start = 1'b0;
        set_stall(0, 0, 0, 0);
        step();
        step();
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_opnd_ready", opnd_ready, 1'b0);
        chkb("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_row", {30'b0, res_row}, 32'h0);
        rst = 1'b0;
        step();

        // Single step, unbroken handshakes: done lands 6 cycles after start
        add_op(32'h04030201, 32'h01010101, 0);
        run(1);
        chk("single_row_ref", model_row(3), 32'h04030201);

        // Two steps with a two-cycle operand gap
        add_op(32'h04030201, 32'h01010101, 0);
        add_op(32'h04030201, 32'h01010101, 2);
        run(2);
        chk("gap_row_ref", model_row(0), 32'h08060402);

        // Lane wrap without carry into the neighbouring lane
        add_op(32'h000000FF, 32'h00000002, 0);
        run(1);
        chk("wrap_row_ref", model_row(0), 32'h000000FE);
        add_op(32'h00000010, 32'h00000010, 0);
        run(1);

        // Backpressure on row 1
        set_stall(0, 3, 0, 0);
        add_op($urandom, $urandom, 0);
        add_op($urandom, $urandom, 1);
        run(2);
        set_stall(0, 0, 0, 0);

        // Clear-and-drain only
        run(0);

        // Start pulses during ACCUM must be ignored
        poke_start = 1'b1;
        for (int p = 0; p < 3; p++) add_op($urandom, $urandom, 2);
        run(3);
        poke_start = 1'b0;

        // Reset after 2 of 4 handshakes
        start = 1'b1;
        k_len = K_W'(4);
        step();
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            opnd_valid = 1'b1;
            opnd_a     = $urandom;
            opnd_b     = $urandom;
            step();
        end
        opnd_valid = 1'b0;
        rst = 1'b1;
        step();
        chkb("midrst_busy", busy, 1'b0);
        chkb("midrst_opnd_ready", opnd_ready, 1'b0);
        chkb("midrst_done", done, 1'b0);
        chkb("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_res_data", res_data, 32'h0);
        rst = 1'b0;
        step();
        chkb("midrst_done_after", done, 1'b0);
        chkb("midrst_busy_after", busy, 1'b0);
        add_op(32'h01010101, 32'h01010101, 0);
        run(1);

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            int k;
            k = $urandom_range(0, 6);
            poke_start = 1'($urandom_range(0, 1));
            set_stall($urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 2));
            for (int p = 0; p < k; p++) add_op($urandom, $urandom, $urandom_range(0, 3));
            run(k);
        end
        poke_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_mac_ctrl.md
Name: matrix_mac_ctrl

Overview:
Sequencer for the 4x4 byte-lane multiply-accumulate datapath (matrix_mul). It owns the four 32-bit accumulator rows M[3:0], clears them on start, and accepts K operand pairs (A column word, B row word) over a valid/ready handshake. Each accepted pair is one rank-1 update through the datapath. It then streams the four result rows out over a second valid/ready handshake. It sits between the custom-instruction issue logic and the operand/result buffers of the matrix extension.

Parameters:
K_W, 8, width of the k_len step-count input (max 255 rank-1 updates)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a new accumulation; sampled only in IDLE
k_len  in  K_W  number of operand pairs to accumulate; 0 = clear-and-drain only
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on the first IDLE cycle after the last result row is accepted
opnd_valid  in  1  operand pair present
opnd_ready  out  1  controller accepts operand pair this cycle
opnd_a  in  32  four unsigned bytes a[i] = opnd_a[8i+7:8i]
opnd_b  in  32  four unsigned bytes b[j] = opnd_b[8j+7:8j]
res_valid  out  1  result row present
res_ready  in  1  consumer accepts result row
res_data  out  32  accumulator row M[res_row]
res_row  out  2  index of the row on res_data

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, M[0..3]=0, step count=0, row index=0; busy, done, opnd_ready, res_valid = 0; res_data=0; res_row=0.
- States: IDLE, ACCUM, DRAIN.
- IDLE, start=1:
  - latch k_len;
  - clear M[0..3] and the step count;
  - go to ACCUM if k_len!=0, else go to DRAIN.
- IDLE, start=0: hold state.
- start while busy is ignored and has no side effect.
- ACCUM:
  - opnd_ready=1.
  - On opnd_valid&&opnd_ready, drive mul_ctrl=`MATRIX_MUL to the datapath with op_A=opnd_a, op_B=opnd_b. Register M[j] <= datapath row j in the same cycle; the datapath is combinational.
  - Count increments on each handshake. The handshake with count==k_len-1 moves the block to DRAIN.
  - No handshake: mul_ctrl is driven to the non-MAC code, M holds, and count holds. Gaps in opnd_valid are legal.
- Arithmetic: M[j][8i+7:8i] <= (M[j][8i+7:8i] + a[i]*b[j]) mod 256, unsigned, per lane. There is no carry between lanes and no saturation.
- DRAIN:
  - res_valid=1, res_data=M[row], res_row=row, with row starting at 0.
  - On res_valid&&res_ready, row increments. The handshake on row 3 sets state=IDLE, done=1 for the next cycle only, and row=0.
  - While res_ready=0, res_data and res_row hold stable.
- opnd_ready=0 outside ACCUM; res_valid=0 outside DRAIN.
- Latency, with opnd_valid and res_ready held high: start cycle, then K ACCUM cycles, then 4 DRAIN cycles, then done in the next cycle. Total 1+K+4 cycles from start to done.
- A start asserted on the done cycle is accepted; the block is in IDLE then.
- rst asserted mid-ACCUM or mid-DRAIN:
  - abort on the next edge;
  - return to reset values;
  - no done pulse.
- M is not cleared at drain end. The values remain visible only through the next DRAIN.

Decomposition:
- Shared define file holds the mul_ctrl encodings (`MATRIX_MUL and the NOP value 4'b0).
- State encodings are local to this module.
- Sub-module: one instance of the existing matrix_mul datapath. The controller feeds it M[3:0], mul_ctrl, op_A and op_B, and registers its four output rows.
- Expected size: about 150-200 lines of RTL.

Test Plan:
- Single step: k_len=1, pair A=0x04030201, B=0x01010101, res_ready=1 → rows 0..3 each 0x04030201, res_row 0,1,2,3; done pulses 6 cycles after start.
- Two steps with an operand gap: k_len=2, same pair twice with opnd_valid low for 2 cycles between → all rows 0x08060402; M unchanged during the gap.
- Lane wrap, no carry: k_len=1, A=0x000000FF, B=0x00000002 → row0=0x000000FE, rows1..3=0; k_len=1, A=0x00000010, B=0x00000010 → row0=0x00000000 (256 mod 256).
- Result backpressure: hold res_ready low for 3 cycles on row 1 → res_data and res_row=1 stable throughout; done only after the row-3 handshake.
- k_len=0 and ignored start: k_len=0 → four rows of 0x00000000, then done. A start pulse during ACCUM changes neither count nor M.
- Reset mid-op: assert rst after 2 of 4 operand handshakes → next cycle busy=0, opnd_ready=0, no done. A subsequent k_len=1 run with A=B=0x01010101 yields rows 0x01010101.
